// File: rtl/pi_arbiter.sv
// pi_arbiter: seven-level priority-interrupt arbiter with CONO/CONI PI register interface.
// Optional program (software) requests are compiled in when PI_SWREQ_EN is defined.
module pi_arbiter (
   input  logic        clk,
   input  logic        rst,
   input  logic        clken,
   input  logic [0:35] dp,
   input  logic        piCONO,
   input  logic        piACK,
   input  logic        piDISMISS,
   input  logic [1:7]  aprINTR,
   input  logic [1:7]  ubaINTR,
   output logic        piINTR,
   output logic [0:2]  piLEVEL,
   output logic [0:35] piSTATUS
);

   logic       pi_on, pi_on_n;
   logic [1:7] pi_ena, pi_ena_n;
   logic [1:7] in_prog, in_prog_n;
   logic [1:7] hw_req, sw_req;
   logic [1:7] eligible, lvl_mask, ack_sel;
   logic [0:2] win_level;
   logic       blocked, dismissed, ack_ok, clear_sys;

   assign lvl_mask  = dp[29:35];
   assign clear_sys = piCONO & dp[22];
   assign ack_ok    = piACK & piINTR;

   // An in-progress level masks itself and every lower-priority level.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred;
      // blocking assignments are intended here because the loop chains 'blocked'.
      eligible  = '0;
      win_level = '0;
      blocked   = 1'b0;
      ack_sel   = '0;
      for (int l = 1; l <= 7; l++) begin
         blocked     = blocked | in_prog[l];
         eligible[l] = pi_on & pi_ena[l] & (hw_req[l] | sw_req[l]) & ~blocked;
         ack_sel[l]  = ack_ok & (piLEVEL == 3'(l));
      end
      for (int l = 7; l >= 1; l--)
         if (eligible[l]) win_level = 3'(l);
   end

   // Dismiss picks from the pre-edge in-progress set, then the ack bit is merged in.
   always_comb begin
      in_prog_n = in_prog;
      pi_ena_n  = pi_ena;
      pi_on_n   = pi_on;
      dismissed = 1'b0;
      if (piDISMISS)
         for (int l = 1; l <= 7; l++)
            if (in_prog[l] && !dismissed) begin
               in_prog_n[l] = 1'b0;
               dismissed    = 1'b1;
            end
      in_prog_n = in_prog_n | ack_sel;
      if (piCONO) begin
         if (dp[25]) pi_ena_n = pi_ena_n | lvl_mask;
         if (dp[26]) pi_ena_n = pi_ena_n & ~lvl_mask;
         if (dp[28]) pi_on_n  = 1'b1;
         if (dp[27]) pi_on_n  = 1'b0;
      end
      if (clear_sys) begin
         in_prog_n = '0;
         pi_ena_n  = '0;
         pi_on_n   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      // NOTE: non-blocking assignments for all sequential state.
      if (!rst) begin
         pi_on   <= 1'b0;
         pi_ena  <= '0;
         in_prog <= '0;
         hw_req  <= '0;
         piINTR  <= 1'b0;
         piLEVEL <= '0;
      end else if (clken) begin
         pi_on   <= pi_on_n;
         pi_ena  <= pi_ena_n;
         in_prog <= in_prog_n;
         hw_req  <= aprINTR | ubaINTR;
         piINTR  <= |eligible;
         piLEVEL <= win_level;
      end
   end

`ifdef PI_SWREQ_EN
   logic [1:7] sw_req_n;
   logic       unused_dp;
   assign unused_dp = ^dp[0:21];

   // Set-then-clear ordering makes a conflicting CONO resolve to clear.
   always_comb begin
      sw_req_n = sw_req & ~ack_sel;
      if (piCONO) begin
         if (dp[24]) sw_req_n = sw_req_n | lvl_mask;
         if (dp[23]) sw_req_n = sw_req_n & ~lvl_mask;
      end
      if (clear_sys) sw_req_n = '0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)       sw_req <= '0;
      else if (clken) sw_req <= sw_req_n;
   end
`else
   logic unused_dp;
   assign unused_dp = ^{dp[0:21], dp[23:24]};
   assign sw_req    = '0;
`endif

   assign piSTATUS = {11'b0, sw_req, 3'b0, in_prog, pi_on, pi_ena};

endmodule

// File: tb/tb_pi_arbiter.sv
// Directed self-checking bench for pi_arbiter: reset, priority, masking, ack/dismiss, CONO.
// Covers both builds; program-request steps depend on PI_SWREQ_EN.
module tb_pi_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        clken;
   logic [0:35] dp;
   logic        piCONO, piACK, piDISMISS;
   logic [1:7]  aprINTR, ubaINTR;
   logic        piINTR;
   logic [0:2]  piLEVEL;
   logic [0:35] piSTATUS;

   int n_cmp = 0;
   int n_bad = 0;
   logic [0:35] w;
   logic [0:35] es;

   pi_arbiter dut (
      .clk       (clk),
      .rst       (rst),
      .clken     (clken),
      .dp        (dp),
      .piCONO    (piCONO),
      .piACK     (piACK),
      .piDISMISS (piDISMISS),
      .aprINTR   (aprINTR),
      .ubaINTR   (ubaINTR),
      .piINTR    (piINTR),
      .piLEVEL   (piLEVEL),
      .piSTATUS  (piSTATUS)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cono(input logic [0:35] d);
      dp     = d;
      piCONO = 1'b1;
      tick();
      piCONO = 1'b0;
      dp     = '0;
   endtask

   initial begin
      rst = 1'b0; clken = 1'b1; dp = '0;
      piCONO = 1'b0; piACK = 1'b0; piDISMISS = 1'b0;
      aprINTR = '0; ubaINTR = '0;
      #3;
      check("reset_intr",   36'(piINTR),  36'd0);
      check("reset_level",  36'(piLEVEL), 36'd0);
      check("reset_status", piSTATUS,     36'd0);
      @(negedge clk);
      rst = 1'b1;
      tick();

      // Enable all levels and turn the system on.
      w = '0; w[25] = 1'b1; w[28] = 1'b1; w[29:35] = 7'h7F;
      cono(w);
      es = '0; es[28] = 1'b1; es[29:35] = 7'h7F;
      check("cono_on_status", piSTATUS, es);

      // Two-edge request latency; level 3 beats level 5.
      aprINTR = 7'b0000100; ubaINTR = 7'b0010000;
      tick();
      check("lat_edge1_intr", 36'(piINTR), 36'd0);
      tick();
      check("lat_edge2_intr",  36'(piINTR),  36'd1);
      check("lat_edge2_level", 36'(piLEVEL), 36'd3);

      // clken low freezes everything, including the request pipeline.
      clken = 1'b0; aprINTR = 7'b1000000;
      tick(); tick();
      check("clken_hold_level", 36'(piLEVEL), 36'd3);
      aprINTR = 7'b0000100; clken = 1'b1;
      tick();
      check("clken_resume_level", 36'(piLEVEL), 36'd3);

      // Ack level 3: level 3 and lower (5) masked.
      piACK = 1'b1; tick(); piACK = 1'b0;
      es[23] = 1'b1;
      check("ack3_status", piSTATUS, es);
      tick();
      check("mask_intr",  36'(piINTR),  36'd0);
      check("mask_level", 36'(piLEVEL), 36'd0);
      piDISMISS = 1'b1; tick(); piDISMISS = 1'b0;
      es[23] = 1'b0;
      check("dismiss3_status", piSTATUS, es);
      tick();
      check("after_dismiss_level", 36'(piLEVEL), 36'd3);

      // Level 6 in progress, level 2 pending, ack+dismiss together.
      aprINTR = '0; ubaINTR = 7'b0000010;
      tick(); tick();
      check("lvl6_level", 36'(piLEVEL), 36'd6);
      piACK = 1'b1; tick(); piACK = 1'b0;
      aprINTR = 7'b0100000;
      tick();
      check("lvl6_busy_intr", 36'(piINTR), 36'd0);
      tick();
      check("lvl2_level", 36'(piLEVEL), 36'd2);
      piACK = 1'b1; piDISMISS = 1'b1; tick(); piACK = 1'b0; piDISMISS = 1'b0;
      es[21:27] = 7'b0100000;
      check("ack_dismiss_status", piSTATUS, es);

      // piON off keeps enables and in-progress; then enable set+clear resolves to clear.
      w = '0; w[27] = 1'b1;
      cono(w);
      es[28] = 1'b0;
      check("off_status", piSTATUS, es);
      tick();
      check("off_intr", 36'(piINTR), 36'd0);
      w = '0; w[25] = 1'b1; w[26] = 1'b1; w[28] = 1'b1; w[29:35] = 7'b1000000;
      cono(w);
      es[28] = 1'b1; es[29:35] = 7'b0111111;
      check("ena_conflict_status", piSTATUS, es);
      w = '0; w[27] = 1'b1; w[28] = 1'b1;
      cono(w);
      es[28] = 1'b0;
      check("on_conflict_status", piSTATUS, es);
      w = '0; w[28] = 1'b1; w[29:35] = 7'h7F; w[25] = 1'b1;
      cono(w);
      es[28] = 1'b1; es[29:35] = 7'h7F;

      // Quiet down: drop requests, dismiss level 2.
      aprINTR = '0; ubaINTR = '0;
      piDISMISS = 1'b1; tick(); piDISMISS = 1'b0;
      es[21:27] = '0;
      check("quiet_status", piSTATUS, es);
      tick();
      check("quiet_intr", 36'(piINTR), 36'd0);

`ifdef PI_SWREQ_EN
      w = '0; w[24] = 1'b1; w[28] = 1'b1; w[29:35] = 7'b0000001;
      cono(w);
      tick();
      check("swreq_level", 36'(piLEVEL), 36'd7);
      piACK = 1'b1; tick(); piACK = 1'b0;
      check("swreq_ack_sw17", 36'(piSTATUS[17]), 36'd0);
      check("swreq_ack_ip27", 36'(piSTATUS[27]), 36'd1);
      piDISMISS = 1'b1; tick(); piDISMISS = 1'b0;
      tick();
`else
      w = '0; w[24] = 1'b1; w[28] = 1'b1; w[29:35] = 7'b0000001;
      cono(w);
      check("noswreq_status", piSTATUS, es);
      tick();
      check("noswreq_intr", 36'(piINTR), 36'd0);
`endif

      // Clear system alongside an ack: everything zeroed, ack discarded.
      ubaINTR = 7'b0001000;
      tick(); tick();
      check("pre_clear_level", 36'(piLEVEL), 36'd4);
      w = '0; w[22] = 1'b1; w[28] = 1'b1;
      dp = w; piCONO = 1'b1; piACK = 1'b1;
      tick();
      piCONO = 1'b0; piACK = 1'b0; dp = '0;
      check("clear_status", piSTATUS, 36'd0);
      tick();
      check("clear_intr", 36'(piINTR), 36'd0);

      // Reset mid-run with level 2 in progress and an ack pending.
      w = '0; w[25] = 1'b1; w[28] = 1'b1; w[29:35] = 7'h7F;
      ubaINTR = 7'b0100000;
      cono(w);
      tick();
      check("pre_reset_level", 36'(piLEVEL), 36'd2);
      piACK = 1'b1; tick();
      check("pre_reset_inprog", 36'(piSTATUS[21:27]), 36'(7'b0100000));
      #2 rst = 1'b0;
      #1;
      check("async_reset_intr",   36'(piINTR),  36'd0);
      check("async_reset_level",  36'(piLEVEL), 36'd0);
      check("async_reset_status", piSTATUS,     36'd0);
      tick();
      check("reset_held_status", piSTATUS, 36'd0);
      #3 rst = 1'b1; piACK = 1'b0; ubaINTR = '0;
      tick();
      check("post_reset_status", piSTATUS, 36'd0);
      check("post_reset_intr",   36'(piINTR), 36'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pi_arbiter.md
PI_ARBITER -- requirements
Module: pi_arbiter

Interface
REQ-001 clk  in  1  system clock; all state SHALL update on the rising edge only.
REQ-002 rst  in  1  asynchronous, active-low reset; SHALL clear all state immediately on assertion, independent of clk and clken.
REQ-003 clken  in  1  clock enable; no state SHALL change except on an edge where clken=1.
REQ-004 dp  in  [0:35]  data path; carries CONO PI write data.
REQ-005 piCONO  in  1  decoded CONO PI strobe; qualified by clken.
REQ-006 piACK  in  1  microcode interrupt-acknowledge strobe; qualified by clken.
REQ-007 piDISMISS  in  1  microcode dismiss strobe (JEN/XJEN); qualified by clken.
REQ-008 aprINTR  in  [1:7]  one-hot APR interrupt request, level-sensitive.
REQ-009 ubaINTR  in  [1:7]  bus-adapter interrupt requests, level-sensitive, any combination.
REQ-010 piINTR  out  1  registered; interrupt pending for the CPU.
REQ-011 piLEVEL  out  [0:2]  registered; winning level 1..7, 0 when piINTR=0.
REQ-012 piSTATUS  out  [0:35]  CONI PI word, combinational from registers.

Function
REQ-013 State: piON, piENA[1:7], piSWREQ[1:7], piINPROG[1:7], hardware request register piHWREQ[1:7], output registers piINTR/piLEVEL.
REQ-014 piHWREQ SHALL load aprINTR|ubaINTR every clken edge (one-stage request pipeline).
REQ-015 Level L SHALL be eligible when piON=1, piENA[L]=1, (piHWREQ[L] or piSWREQ[L])=1, and piINPROG[k]=0 for every k<=L.
REQ-016 Level 1 SHALL be highest priority; piLEVEL/piINTR SHALL load the highest eligible level (or 0/0) each clken edge.
REQ-017 Latency: request input to piINTR SHALL be exactly two clken edges; piHWREQ change to piINTR exactly one.
REQ-018 CONO decode (piCONO=1): dp[22] clear system (piON, piENA, piSWREQ, piINPROG := 0); dp[23] clear piSWREQ for levels in dp[29:35]; dp[24] set piSWREQ for dp[29:35]; dp[25] set piENA for dp[29:35]; dp[26] clear piENA for dp[29:35]; dp[27] piON:=0; dp[28] piON:=1.
REQ-019 CONO bit conflicts: set-and-clear of the same bit in one write SHALL resolve to clear; dp[22] SHALL override every other field.
REQ-020 piACK with piINTR=1 SHALL set piINPROG[piLEVEL] and clear piSWREQ[piLEVEL]; piACK with piINTR=0 SHALL be ignored.
REQ-021 piDISMISS SHALL clear only the highest-priority set piINPROG bit; with none set it SHALL be ignored.
REQ-022 piACK and piDISMISS together: dismiss SHALL select from pre-edge piINPROG, then the ack bit SHALL be set; both applied in one edge.
REQ-023 piCONO with piACK or piDISMISS: CONO effects applied; if dp[22]=1, ack/dismiss SHALL be discarded; otherwise all SHALL be applied.
REQ-024 piSTATUS: [11:17]=piSWREQ, [21:27]=piINPROG, [28]=piON, [29:35]=piENA, all other bits 0.
REQ-025 Turning piON off SHALL not clear piINPROG, piSWREQ or piENA.

Reset
REQ-026 On rst=0 all registers SHALL be 0: piINTR=0, piLEVEL=3'b000, piSTATUS=36'b0, regardless of clken.
REQ-027 Reset mid-acknowledge SHALL discard the pending ack; the first clken edge after release SHALL evaluate from zeroed state.

Configuration
REQ-028 Macro PI_SWREQ_EN: when defined, program requests (piSWREQ, CONO dp[23], dp[24]) SHALL behave as above.
REQ-029 Without PI_SWREQ_EN, piSWREQ SHALL be constant 0, dp[23]/dp[24] ignored, piSTATUS[11:17]=0.

Verification
REQ-030 Reset: assert rst=0 mid-run with piINPROG=7'b0100000 -> all outputs 0 immediately, piSTATUS=0.
REQ-031 Priority: CONO dp[25,28,29:35]=1,1,7'h7F; aprINTR=7'b0000100, ubaINTR=7'b0010000 -> after 2 clken edges piINTR=1, piLEVEL=3.
REQ-032 In-progress masking: piACK at level 3, ubaINTR level 3 held, aprINTR level 5 -> piINTR=0; piDISMISS -> next edge piLEVEL=3.
REQ-033 Simultaneous: piINPROG=7'b0000010 (level 6), piLEVEL=2 pending, assert piACK+piDISMISS together -> piINPROG=7'b0100000.
REQ-034 Software request (PI_SWREQ_EN): CONO dp[24,28]=1 with dp[29:35]=7'b0000001, piENA[7]=1 -> piLEVEL=7; piACK -> piSTATUS[17]=0, piSTATUS[27]=1.
REQ-035 Clear system: CONO with dp[22]=1 and dp[28]=1 alongside piACK -> piON=0, piINPROG=0, piINTR=0 next edge.
